vga_scan_out: RTL



---
 rtl/vga_scan_out.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vga_scan_out.sv
// vga_scan_out: 640x480@60 VGA timing with a small pixel FIFO and registered RGB/sync outputs.
// Optional colour-bar generator, enabled by defining VGA_TEST_PATTERN_EN, adds the test_mode input.
module vga_scan_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de,
  output logic       frame_start,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  output logic       underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [CW-1:0] FULL_C   = CW'(FIFO_DEPTH);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, urun_q, urun_d;

  logic          active, empty, full, push, pop, tm;
  logic [23:0]   pat;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);
  logic [2:0] bar_idx;
  assign tm      = test_mode;
  assign bar_idx = 3'(h_q / BAR_W);
  // Bar order white..black maps to inverted index bits: r=~b1, g=~b2, b=~b0.
  assign pat     = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
`else
  assign tm  = 1'b0;
  assign pat = '0;
`endif

  assign active    = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_C);
  assign pix_ready = rst_n & ~full;
  assign push      = pix_valid & pix_ready;
  assign pop       = active & ~empty & ~tm;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    rgb_d = '0;
    if (active) begin
      if (tm)          rgb_d = pat;
      else if (!empty) rgb_d = mem_q[rd_ptr_q];
    end
    de_d   = active;
    hs_d   = ~((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
    vs_d   = ~((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));
    fs_d   = (h_q == '0) && (v_q == '0);
    urun_d = urun_q | (active & empty & ~tm);
  end

  // Storage is not reset; a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {red_in, green_in, blue_in};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q      <= '0;
      v_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      urun_q   <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
      urun_q   <= urun_d;
    end
  end

  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign frame_start = fs_q;
  assign underrun    = urun_q;

endmodule
